matvec_stream_driver: RTL and testbench

Initiator-side companion for matrix_mult_vector. It packs a serial element stream into the flat i_matrix/i_vector buses and runs the clear/calc/ready handshake. It then captures o_result and streams the result elements back out. It sits between a word-wide valid/ready source/sink (host or DMA) and one multiplier instance.

---
 rtl/matvec_pkg.sv | 19 +
 rtl/matvec_elem_packer.sv | 34 +++
 rtl/matvec_stream_driver.sv | 133 +++++++++++++
 tb/tb_matvec_stream_driver.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/matvec_pkg.sv
// Shared types and helpers for the matrix_mult_vector stream driver.
package matvec_pkg;

    localparam int STATE_WIDTH = 3;

    typedef enum logic [STATE_WIDTH-1:0] {
        LOAD_M,
        LOAD_V,
        CLEAR,
        CALC,
        OUT
    } state_t;

    // Counter width for a 0..n-1 range; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matvec_elem_packer.sv
// Writes a stream of DATA_WIDTH words into an N-element flat register, first word at the LSB.
module matvec_elem_packer
    import matvec_pkg::*;
#(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [DATA_WIDTH-1:0]   data,
    output logic [N*DATA_WIDTH-1:0] flat,
    output logic                    done
);
    localparam int            CW   = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] cnt;

    assign done = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            // NOTE: the flat register drives the multiplier bus directly, so it is reset like any other output.
            flat <= '0;
        end else if (we) begin
            // NOTE: non-blocking assignments keep every register update on the same clock edge.
            flat[cnt*DATA_WIDTH +: DATA_WIDTH] <= data;
            cnt <= done ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/matvec_stream_driver.sv
// Initiator-side driver for matrix_mult_vector: packs the input stream, runs the
// clear/calc/ready handshake and streams the captured result elements back out.
module matvec_stream_driver
    import matvec_pkg::*;
#(
    parameter int MATRIX_WIDTH  = 2,
    parameter int MATRIX_HEIGHT = 2,
    parameter int DATA_WIDTH    = 8,
    parameter int MATRIX_WEIGHT = MATRIX_WIDTH * MATRIX_HEIGHT,
    parameter int TIMEOUT       = 64
) (
    input  logic                                clk,
    input  logic                                i_rst_n,
    input  logic                                i_in_valid,
    output logic                                o_in_ready,
    input  logic [DATA_WIDTH-1:0]               i_in_data,
    output logic                                o_out_valid,
    input  logic                                i_out_ready,
    output logic [DATA_WIDTH-1:0]               o_out_data,
    output logic                                o_out_last,
    output logic                                o_error,
    output logic                                o_mul_rst_n,
    output logic                                o_mul_calc,
    output logic [MATRIX_WEIGHT*DATA_WIDTH-1:0] o_mul_matrix,
    output logic [MATRIX_WIDTH*DATA_WIDTH-1:0]  o_mul_vector,
    input  logic [MATRIX_WEIGHT*DATA_WIDTH-1:0] i_mul_result,
    input  logic                                i_mul_ready
);
    localparam int            KW        = cnt_width(MATRIX_HEIGHT);
    localparam int            WW        = cnt_width(TIMEOUT);
    localparam int            RW        = MATRIX_HEIGHT * DATA_WIDTH;
    localparam logic [KW-1:0] LAST_K    = KW'(MATRIX_HEIGHT - 1);
    localparam logic [WW-1:0] LAST_WAIT = WW'(TIMEOUT - 1);

    state_t        state, state_next;
    logic [KW-1:0] out_idx;
    logic [WW-1:0] wait_cnt;
    logic [RW-1:0] result;
    logic          m_we, v_we, m_done, v_done;
    logic          capture, timeout, out_xfer;

    matvec_elem_packer #(.N(MATRIX_WEIGHT), .DATA_WIDTH(DATA_WIDTH)) u_matrix_packer (
        .clk   (clk),
        .rst_n (i_rst_n),
        .we    (m_we),
        .data  (i_in_data),
        .flat  (o_mul_matrix),
        .done  (m_done)
    );

    matvec_elem_packer #(.N(MATRIX_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_vector_packer (
        .clk   (clk),
        .rst_n (i_rst_n),
        .we    (v_we),
        .data  (i_in_data),
        .flat  (o_mul_vector),
        .done  (v_done)
    );

    // Only the first MATRIX_HEIGHT result elements are meaningful to the host.
    generate
        if (RW < MATRIX_WEIGHT * DATA_WIDTH) begin : g_unused_result
            logic unused_result_hi;
            assign unused_result_hi = ^i_mul_result[MATRIX_WEIGHT*DATA_WIDTH-1:RW];
        end
    endgenerate

    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        state_next  = state;
        o_mul_rst_n = 1'b1;
        o_mul_calc  = 1'b0;
        o_out_valid = 1'b0;
        m_we        = 1'b0;
        v_we        = 1'b0;
        capture     = 1'b0;
        timeout     = 1'b0;
        out_xfer    = 1'b0;
        unique case (state)
            LOAD_M: begin
                m_we = i_in_valid && o_in_ready;
                if (m_we && m_done) state_next = LOAD_V;
            end
            LOAD_V: begin
                v_we = i_in_valid && o_in_ready;
                if (v_we && v_done) state_next = CLEAR;
            end
            CLEAR: begin
                o_mul_rst_n = 1'b0;
                state_next  = CALC;
            end
            CALC: begin
                o_mul_calc = 1'b1;
                if (i_mul_ready) begin
                    capture    = 1'b1;
                    state_next = OUT;
                end else if (wait_cnt == LAST_WAIT) begin
                    timeout    = 1'b1;
                    state_next = LOAD_M;
                end
            end
            OUT: begin
                o_out_valid = 1'b1;
                out_xfer    = i_out_ready;
                if (out_xfer && out_idx == LAST_K) state_next = LOAD_M;
            end
            default: state_next = LOAD_M;
        endcase
    end

    assign o_out_data = result[out_idx*DATA_WIDTH +: DATA_WIDTH];
    assign o_out_last = o_out_valid && (out_idx == LAST_K);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= LOAD_M;
            o_in_ready <= 1'b0;
            o_error    <= 1'b0;
            wait_cnt   <= '0;
            out_idx    <= '0;
            result     <= '0;
        end else begin
            state <= state_next;
            // Registered so the source sees ready low while reset is asserted.
            o_in_ready <= (state_next == LOAD_M) || (state_next == LOAD_V);
            o_error    <= timeout;
            wait_cnt   <= (state == CALC && state_next == CALC) ? wait_cnt + 1'b1 : '0;
            if (capture) result <= i_mul_result[RW-1:0];
            if (out_xfer) out_idx <= (out_idx == LAST_K) ? '0 : out_idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_matvec_stream_driver.sv
// Self-checking bench for matvec_stream_driver: vector table, hand-written corner cases
// and randomized transactions against a behavioural packing/streaming model.
module tb_matvec_stream_driver;
    localparam int MW  = 2;
    localparam int MH  = 2;
    localparam int DW  = 8;
    localparam int MWT = MW * MH;
    localparam int TO  = 64;

    logic              clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              i_in_valid = 1'b0;
    logic              o_in_ready;
    logic [DW-1:0]     i_in_data = '0;
    logic              o_out_valid;
    logic              i_out_ready = 1'b0;
    logic [DW-1:0]     o_out_data;
    logic              o_out_last;
    logic              o_error;
    logic              o_mul_rst_n;
    logic              o_mul_calc;
    logic [MWT*DW-1:0] o_mul_matrix;
    logic [MW*DW-1:0]  o_mul_vector;
    logic [MWT*DW-1:0] i_mul_result = '0;
    logic              i_mul_ready = 1'b0;

    always #5 clk = ~clk;

    matvec_stream_driver #(
        .MATRIX_WIDTH (MW),
        .MATRIX_HEIGHT(MH),
        .DATA_WIDTH   (DW),
        .TIMEOUT      (TO)
    ) dut (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_data   (i_in_data),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_data  (o_out_data),
        .o_out_last  (o_out_last),
        .o_error     (o_error),
        .o_mul_rst_n (o_mul_rst_n),
        .o_mul_calc  (o_mul_calc),
        .o_mul_matrix(o_mul_matrix),
        .o_mul_vector(o_mul_vector),
        .i_mul_result(i_mul_result),
        .i_mul_ready (i_mul_ready)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  m0, m1, m2, m3, v0, v1;
        int          gap, lat, stall;
        logic [31:0] res;
        logic [31:0] exp_mat;
        logic [15:0] exp_vec;
        logic [7:0]  exp_d0, exp_d1;
    } vec_t;

    vec_t       tbl [4];
    logic [7:0] stim_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [7:0] m0, m1, m2, m3, v0, v1,
                                input int gap, lat, stall, input logic [31:0] res,
                                input logic [31:0] exp_mat, input logic [15:0] exp_vec,
                                input logic [7:0] d0, d1);
        vec_t v;
        v.m0 = m0; v.m1 = m1; v.m2 = m2; v.m3 = m3; v.v0 = v0; v.v1 = v1;
        v.gap = gap; v.lat = lat; v.stall = stall; v.res = res;
        v.exp_mat = exp_mat; v.exp_vec = exp_vec; v.exp_d0 = d0; v.exp_d1 = d1;
        return v;
    endfunction

    task automatic load_q(input vec_t v);
        stim_q.delete();
        stim_q.push_back(v.m0); stim_q.push_back(v.m1);
        stim_q.push_back(v.m2); stim_q.push_back(v.m3);
        stim_q.push_back(v.v0); stim_q.push_back(v.v1);
    endtask

    task automatic send_elem(input logic [7:0] d);
        int n;
        n = 0;
        i_in_valid = 1'b1;
        i_in_data  = d;
        while (!o_in_ready && n < 50) begin
            step();
            n++;
        end
        check("in_ready_wait", 64'(n < 50), 1);
        step();
        i_in_valid = 1'b0;
        i_in_data  = 8'($urandom);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},  o_in_ready,   0);
        check({tag, "_out_valid"}, o_out_valid,  0);
        check({tag, "_out_last"},  o_out_last,   0);
        check({tag, "_error"},     o_error,      0);
        check({tag, "_mul_rst_n"}, o_mul_rst_n,  1);
        check({tag, "_mul_calc"},  o_mul_calc,   0);
        check({tag, "_matrix"},    o_mul_matrix, 0);
        check({tag, "_vector"},    o_mul_vector, 0);
        check({tag, "_out_data"},  o_out_data,   0);
    endtask

    // Streams stim_q in, plays the multiplier (lat < 0: never ready), then drains the output.
    task automatic do_txn(input string tag, input int gap, lat, stall, input logic [31:0] res,
                          input logic [31:0] exp_mat, input logic [15:0] exp_vec,
                          input logic [7:0] d0, d1, input bit noise);
        int calc_cycles;
        int err_cycles;
        for (int i = 0; i < stim_q.size(); i++) begin
            i_mul_ready = noise ? 1'($urandom_range(1)) : 1'b0;
            repeat ($urandom_range(gap)) step();
            send_elem(stim_q[i]);
        end
        i_mul_ready = 1'b0;
        check({tag, "_clear_rst_n"}, o_mul_rst_n,  0);
        check({tag, "_clear_calc"},  o_mul_calc,   0);
        check({tag, "_matrix"},      o_mul_matrix, exp_mat);
        check({tag, "_vector"},      o_mul_vector, exp_vec);
        step();
        check({tag, "_calc_rise"},   o_mul_calc,   1);
        check({tag, "_calc_rst_n"},  o_mul_rst_n,  1);
        if (lat < 0) begin
            calc_cycles = 0;
            err_cycles  = 0;
            while (o_mul_calc && calc_cycles < 200) begin
                calc_cycles++;
                if (o_error) err_cycles++;
                step();
            end
            check({tag, "_calc_cycles"}, calc_cycles, TO);
            check({tag, "_ready_after_to"}, o_in_ready, 1);
            repeat (3) begin
                if (o_error) err_cycles++;
                step();
            end
            check({tag, "_error_pulses"}, err_cycles, 1);
            check({tag, "_no_out_valid"}, o_out_valid, 0);
            check({tag, "_matrix_kept"}, o_mul_matrix, exp_mat);
        end else begin
            if (noise) begin
                i_in_valid = 1'b1;
                i_in_data  = 8'($urandom);
            end
            repeat (lat) step();
            check({tag, "_calc_held"},  o_mul_calc,   1);
            check({tag, "_mat_stable"}, o_mul_matrix, exp_mat);
            check({tag, "_vec_stable"}, o_mul_vector, exp_vec);
            i_mul_ready  = 1'b1;
            i_mul_result = res;
            step();
            i_mul_ready  = 1'b0;
            i_mul_result = ~res;
            i_in_valid   = 1'b0;
            check({tag, "_first_valid"}, o_out_valid, 1);
            check({tag, "_calc_drop"},   o_mul_calc,  0);
            for (int s = 0; s < stall; s++) begin
                check({tag, "_stall_data"},  o_out_data,  d0);
                check({tag, "_stall_valid"}, o_out_valid, 1);
                step();
            end
            i_out_ready = 1'b1;
            check({tag, "_d0"},    o_out_data, d0);
            check({tag, "_last0"}, o_out_last, 0);
            step();
            check({tag, "_d1"},     o_out_data,  d1);
            check({tag, "_last1"},  o_out_last,  1);
            check({tag, "_valid1"}, o_out_valid, 1);
            step();
            i_out_ready = 1'b0;
            check({tag, "_done_valid"}, o_out_valid, 0);
            check({tag, "_done_ready"}, o_in_ready,  1);
        end
    endtask

    always @(negedge clk) begin
        if (i_rst_n === 1'b1 && (o_mul_calc || !o_mul_rst_n || o_out_valid))
            check("busy_in_ready", o_in_ready, 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_mat;
        logic [15:0] exp_vec;
        logic [31:0] res;
        vec_t        v;

        tbl[0] = mk(8'h0E, 8'h06, 8'h03, 8'h02, 8'h0E, 8'h0A, 0, 3, 0, 32'h0000_A8D8,
                    32'h0203_060E, 16'h0A0E, 8'hD8, 8'hA8);
        tbl[1] = mk(8'h0E, 8'h06, 8'h03, 8'h02, 8'h0E, 8'h0A, 3, 3, 5, 32'h0000_A8D8,
                    32'h0203_060E, 16'h0A0E, 8'hD8, 8'hA8);
        tbl[2] = mk(8'hFF, 8'h00, 8'h80, 8'h01, 8'h7F, 8'h01, 0, 0, 1, 32'hDEAD_BEEF,
                    32'h0180_00FF, 16'h017F, 8'hEF, 8'hBE);
        tbl[3] = mk(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 1, -1, 0, 32'h0,
                    32'h4433_2211, 16'h6655, 8'h00, 8'h00);

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        i_rst_n = 1'b1;
        step();
        check("rst_release_ready", o_in_ready, 1);

        for (int t = 0; t < 4; t++) begin
            load_q(tbl[t]);
            do_txn($sformatf("tbl%0d", t), tbl[t].gap, tbl[t].lat, tbl[t].stall, tbl[t].res,
                   tbl[t].exp_mat, tbl[t].exp_vec, tbl[t].exp_d0, tbl[t].exp_d1, 1'b0);
        end

        // Reset in the middle of a matrix load, then a fresh load must start at index 0.
        send_elem(8'hAA);
        send_elem(8'hBB);
        i_rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        step();
        i_rst_n = 1'b1;
        step();
        check("midrst_ready", o_in_ready, 1);
        load_q(tbl[0]);
        do_txn("post_rst", 0, 3, 0, tbl[0].res, tbl[0].exp_mat, tbl[0].exp_vec,
               tbl[0].exp_d0, tbl[0].exp_d1, 1'b0);

        for (int r = 0; r < 12; r++) begin
            v.m0 = 8'($urandom); v.m1 = 8'($urandom); v.m2 = 8'($urandom);
            v.m3 = 8'($urandom); v.v0 = 8'($urandom); v.v1 = 8'($urandom);
            load_q(v);
            exp_mat = '0;
            exp_vec = '0;
            for (int n = 0; n < MWT; n++) exp_mat = exp_mat + (32'(stim_q[n]) << (8 * n));
            for (int n = 0; n < MW; n++)  exp_vec = exp_vec + (16'(stim_q[MWT + n]) << (8 * n));
            res = $urandom;
            do_txn($sformatf("rnd%0d", r), int'($urandom_range(3)), int'($urandom_range(8)),
                   int'($urandom_range(3)), res, exp_mat, exp_vec,
                   8'(res >> 0), 8'(res >> 8), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
